// File: rtl/prbs_par_checker.sv
// rtl/prbs_par_checker.sv - parallel self-synchronising PRBS checker (optional: PRBS_CHK_SATURATE_EN)
module prbs_par_checker #(
  parameter int DW          = 8,
  parameter int LOCK_BEATS  = 16,
  parameter int WIN_BEATS   = 1024,
  parameter int LOSS_THRESH = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [1:0]              poly_sel,
  input  logic [DW-1:0]           data_in,
  input  logic                    data_valid,
  output logic                    locked,
  output logic [$clog2(DW+1)-1:0] beat_err,
  output logic                    beat_err_valid,
  output logic [63:0]             total_bits,
  output logic [63:0]             total_bit_errors,
  output logic [15:0]             lock_loss_count
);

  localparam int EW = $clog2(DW+1);
  localparam int GW = $clog2(LOCK_BEATS+1);
  localparam int WW = $clog2(WIN_BEATS);

  typedef enum logic {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    poly_q;
  logic [62:0]   sr_q, sr_d;
  logic [6:0]    fill_q, fill_d;
  logic [GW-1:0] good_q, good_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [31:0]   win_err_q, win_err_d;

  // first pipeline stage: mismatch count of the beat accepted last cycle
  logic          pv_q, pv_d;
  logic [EW-1:0] perr_q, perr_d;
  logic          pcnt_q, pcnt_d;
  logic          phunt_q, phunt_d;

  logic [EW-1:0] beat_err_q, beat_err_d;
  logic          bev_q, bev_d;
  logic [63:0]   tbits_q, tbits_d;
  logic [63:0]   terr_q, terr_d;
  logic [15:0]   loss_q, loss_d;

  logic [6:0]    order;
  logic [5:0]    ord_m1;
  logic [5:0]    tap_m1;
  logic [62:0]   sr_v;
  logic [EW-1:0] nerr;
  logic          pbit;
  logic [32:0]   win_sum;
  logic [7:0]    fill_sum;

  function automatic logic [63:0] add64(input logic [63:0] a, input logic [63:0] b);
`ifdef PRBS_CHK_SATURATE_EN
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[64] ? '1 : s[63:0];
`else
    return a + b;
`endif
  endfunction

  // polynomial geometry from the latched selection
  always_comb begin
    order  = 7'd7;
    ord_m1 = 6'd6;
    tap_m1 = 6'd5;
    case (poly_q)
      2'd0: begin order = 7'd7;  ord_m1 = 6'd6;  tap_m1 = 6'd5;  end
      2'd1: begin order = 7'd15; ord_m1 = 6'd14; tap_m1 = 6'd13; end
      2'd2: begin order = 7'd31; ord_m1 = 6'd30; tap_m1 = 6'd27; end
      default: begin order = 7'd63; ord_m1 = 6'd62; tap_m1 = 6'd61; end
    endcase
  end

  // unrolled serial prediction over the beat, earliest bit (MSB) first
  always_comb begin
    sr_v = sr_q;
    nerr = '0;
    pbit = 1'b0;
    for (int i = DW-1; i >= 0; i--) begin
      pbit = sr_v[ord_m1] ^ sr_v[tap_m1];
      if (pbit != data_in[i]) nerr = nerr + EW'(1);
      // hunting follows the line; locked free-runs so errors are not absorbed
      sr_v = {sr_v[61:0], (state_q == ST_LOCKED) ? pbit : data_in[i]};
    end
  end

  // next state: accept stage, then decision stage for the previous beat
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    fill_d     = fill_q;
    good_d     = good_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    pv_d       = 1'b0;
    perr_d     = perr_q;
    pcnt_d     = pcnt_q;
    phunt_d    = phunt_q;
    beat_err_d = beat_err_q;
    bev_d      = 1'b0;
    tbits_d    = tbits_q;
    terr_d     = terr_q;
    loss_d     = loss_q;
    win_sum    = {1'b0, win_err_q} + 33'(perr_q);
    fill_sum   = {1'b0, fill_q} + 8'(DW);

    if (data_valid) begin
      sr_d    = sr_v;
      pv_d    = 1'b1;
      phunt_d = (state_q == ST_HUNT);
      pcnt_d  = (state_q == ST_LOCKED) || (fill_q == order);
      perr_d  = pcnt_d ? nerr : '0;
      if (state_q == ST_HUNT)
        fill_d = (fill_sum >= {1'b0, order}) ? order : fill_sum[6:0];
    end

    if (pv_q) begin
      bev_d      = 1'b1;
      beat_err_d = perr_q;
      if (state_q == ST_HUNT) begin
        if (perr_q != '0) begin
          good_d = '0;
        end else if (pcnt_q && phunt_q) begin
          if (good_q == GW'(LOCK_BEATS-1)) begin
            state_d   = ST_LOCKED;
            good_d    = '0;
            fill_d    = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end
      end else begin
        tbits_d = add64(tbits_q, 64'(DW));
        terr_d  = add64(terr_q, 64'(perr_q));
        if (win_sum > 33'(LOSS_THRESH)) begin
          state_d   = ST_HUNT;
`ifdef PRBS_CHK_SATURATE_EN
          loss_d    = (&loss_q) ? loss_q : loss_q + 16'd1;
`else
          loss_d    = loss_q + 16'd1;
`endif
          win_cnt_d = '0;
          win_err_d = '0;
          good_d    = '0;
          fill_d    = '0;
        end else if (win_cnt_q == WW'(WIN_BEATS-1)) begin
          win_cnt_d = '0;
          win_err_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + WW'(1);
          win_err_d = win_sum[32] ? '1 : win_sum[31:0];
        end
      end
    end
  end

  // state registers; polynomial latched only while in reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_HUNT;
      poly_q     <= poly_sel;
      sr_q       <= '0;
      fill_q     <= '0;
      good_q     <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      pv_q       <= 1'b0;
      perr_q     <= '0;
      pcnt_q     <= 1'b0;
      phunt_q    <= 1'b0;
      beat_err_q <= '0;
      bev_q      <= 1'b0;
      tbits_q    <= '0;
      terr_q     <= '0;
      loss_q     <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      fill_q     <= fill_d;
      good_q     <= good_d;
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
      pv_q       <= pv_d;
      perr_q     <= perr_d;
      pcnt_q     <= pcnt_d;
      phunt_q    <= phunt_d;
      beat_err_q <= beat_err_d;
      bev_q      <= bev_d;
      tbits_q    <= tbits_d;
      terr_q     <= terr_d;
      loss_q     <= loss_d;
    end
  end

  assign locked           = (state_q == ST_LOCKED);
  assign beat_err         = beat_err_q;
  assign beat_err_valid   = bev_q;
  assign total_bits       = tbits_q;
  assign total_bit_errors = terr_q;
  assign lock_loss_count  = loss_q;

endmodule

// File: tb/tb_prbs_par_checker.sv
// tb/tb_prbs_par_checker.sv - table-driven bench for prbs_par_checker
module tb_prbs_par_checker;

  localparam int DW = 8;
  localparam int EW = $clog2(DW+1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [1:0]    poly_sel = 2'd0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          locked;
  logic [EW-1:0] beat_err;
  logic          beat_err_valid;
  logic [63:0]   total_bits;
  logic [63:0]   total_bit_errors;
  logic [15:0]   lock_loss_count;

  prbs_par_checker #(.DW(DW)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .poly_sel         (poly_sel),
    .data_in          (data_in),
    .data_valid       (data_valid),
    .locked           (locked),
    .beat_err         (beat_err),
    .beat_err_valid   (beat_err_valid),
    .total_bits       (total_bits),
    .total_bit_errors (total_bit_errors),
    .lock_loss_count  (lock_loss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stream source: b[n] = b[n-ORDER] ^ b[n-TAP]
  logic [62:0] g;
  int          g_ord;
  int          g_tap;

  typedef struct {
    bit          do_reset;
    logic [1:0]  poly;
    int          n_beats;
    int          err_start;
    int          err_cnt;
    logic [DW-1:0] flip;
    bit          gaps;
    bit          exp_locked;
    longint      exp_bits;
    longint      exp_errs;
    int          exp_loss;
  } row_t;

  row_t rows[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] flip);
    logic [DW-1:0] w;
    logic          b;
    @(negedge clk);
    data_valid = v;
    if (v) begin
      w = '0;
      for (int i = DW-1; i >= 0; i--) begin
        b = g[g_ord-1] ^ g[g_tap-1];
        g = {g[61:0], b};
        w[i] = b;
      end
      data_in = w ^ flip;
    end else begin
      data_in = DW'($urandom);
    end
  endtask

  task automatic apply_reset(input logic [1:0] p);
    @(negedge clk);
    rstn = 1'b0;
    poly_sel = p;
    data_valid = 1'b0;
    @(negedge clk);
    check("reset locked", locked, 0);
    check("reset beat_err", beat_err, 0);
    check("reset beat_err_valid", beat_err_valid, 0);
    check("reset total_bits", total_bits, 0);
    check("reset total_bit_errors", total_bit_errors, 0);
    check("reset lock_loss_count", lock_loss_count, 0);
    rstn = 1'b1;
    poly_sel = p ^ 2'b01;
    g = 63'({$urandom, $urandom});
    g[0] = 1'b1;
    case (p)
      2'd0: begin g_ord = 7;  g_tap = 6;  end
      2'd1: begin g_ord = 15; g_tap = 14; end
      2'd2: begin g_ord = 31; g_tap = 28; end
      default: begin g_ord = 63; g_tap = 62; end
    endcase
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      if (rows[r].do_reset) apply_reset(rows[r].poly);
      for (int b = 0; b < rows[r].n_beats; b++) begin
        if (rows[r].gaps && ($urandom_range(0, 1) == 1)) drive(1'b0, '0);
        drive(1'b1, (b >= rows[r].err_start && b < rows[r].err_start + rows[r].err_cnt)
                    ? rows[r].flip : '0);
      end
      drive(1'b0, '0);
      drive(1'b0, '0);
      check($sformatf("row%0d locked", r), locked, rows[r].exp_locked);
      check($sformatf("row%0d total_bits", r), total_bits, rows[r].exp_bits);
      check($sformatf("row%0d total_bit_errors", r), total_bit_errors, rows[r].exp_errs);
      check($sformatf("row%0d lock_loss_count", r), lock_loss_count, rows[r].exp_loss);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rst poly beats estart ecnt flip   gaps lock bits   errs loss
    rows[0]  = '{1'b0, 2'd2, 998,  0,  0,  8'h00, 1'b0, 1'b1, 8000,  0,  0};
    rows[1]  = '{1'b0, 2'd2, 1000, 0,  0,  8'h00, 1'b1, 1'b1, 16000, 0,  0};
    rows[2]  = '{1'b1, 2'd0, 20,   0,  0,  8'h00, 1'b0, 1'b1, 24,    0,  0};
    rows[3]  = '{1'b0, 2'd0, 10,   0,  10, 8'h01, 1'b0, 1'b1, 104,   10, 0};
    rows[4]  = '{1'b1, 2'd3, 30,   0,  0,  8'h00, 1'b0, 1'b1, 48,    0,  0};
    rows[5]  = '{1'b0, 2'd3, 64,   0,  64, 8'h20, 1'b0, 1'b1, 560,   64, 0};
    rows[6]  = '{1'b0, 2'd3, 22,   0,  0,  8'h00, 1'b0, 1'b0, 568,   65, 1};
    rows[7]  = '{1'b0, 2'd3, 1,    0,  0,  8'h00, 1'b0, 1'b1, 568,   65, 1};
    rows[8]  = '{1'b1, 2'd2, 37,   18, 1,  8'h80, 1'b0, 1'b0, 0,     0,  0};
    rows[9]  = '{1'b0, 2'd2, 1,    0,  0,  8'h00, 1'b0, 1'b1, 0,     0,  0};
    rows[10] = '{1'b1, 2'd1, 25,   0,  0,  8'h00, 1'b0, 1'b1, 56,    0,  0};
    rows[11] = '{1'b0, 2'd2, 120,  0,  0,  8'h00, 1'b0, 1'b1, 800,   0,  0};

    // PRBS31 lock edge: 4 fill beats + 16 clean beats, locked at edge 21
    apply_reset(2'd2);
    for (int i = 0; i < 20; i++) drive(1'b1, '0);
    drive(1'b1, '0);
    check("locked after edge 20", locked, 0);
    drive(1'b1, '0);
    check("locked after edge 21", locked, 1);
    check("bits at lock", total_bits, 0);
    check("beat_err_valid at lock", beat_err_valid, 1);
    check("beat_err at lock", beat_err, 0);

    run_rows(0, 3);

    // single-bit error: one-cycle beat_err_valid pulse with beat_err=1
    drive(1'b1, 8'h04);
    drive(1'b0, '0);
    drive(1'b0, '0);
    check("pulse beat_err", beat_err, 1);
    check("pulse beat_err_valid", beat_err_valid, 1);
    check("pulse total_bit_errors", total_bit_errors, 11);
    drive(1'b0, '0);
    check("pulse end beat_err_valid", beat_err_valid, 0);

    run_rows(4, 5);

    // 65th error in the window drops lock one edge after its beat
    drive(1'b1, 8'h20);
    drive(1'b1, '0);
    check("loss edge-1 locked", locked, 1);
    drive(1'b1, '0);
    check("loss edge locked", locked, 0);
    check("loss edge lock_loss_count", lock_loss_count, 1);
    check("loss edge total_bit_errors", total_bit_errors, 65);
    check("loss edge total_bits", total_bits, 568);

    run_rows(6, 10);

    // reset while locked on PRBS15, with a beat in flight, switching to PRBS31
    drive(1'b1, '0);
    apply_reset(2'd2);

    run_rows(11, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
